// File: rtl/manchester_tx_arbiter_if.sv
// Bundle of the two requester handshakes and the NRZ stream side of the
// Manchester transmit arbiter.
interface manchester_tx_arbiter_if;
    logic       req_a;
    logic [7:0] data_a;
    logic       ack_a;
    logic       req_b;
    logic [7:0] data_b;
    logic       ack_b;
    logic       nrz_out;
    logic       bit_phase;
    logic       busy;
    logic       owner;
    logic       frame_done;
    logic [1:0] state_dbg;

    // Arbiter side: consumes requests and produces the bit stream.
    modport slave (
        input  req_a, data_a, req_b, data_b,
        output ack_a, ack_b, nrz_out, bit_phase, busy, owner, frame_done, state_dbg
    );

    // Requester / observer side.
    modport master (
        output req_a, data_a, req_b, data_b,
        input  ack_a, ack_b, nrz_out, bit_phase, busy, owner, frame_done, state_dbg
    );
endinterface

// File: rtl/manchester_tx_arbiter.sv
// Round-robin arbiter between two byte requesters feeding an NRZ stream:
// each frame is a 4-bit preamble, the byte MSB first, then idle gap bits.
module manchester_tx_arbiter #(
    parameter logic [3:0]  PREAMBLE = 4'b1010,
    parameter int unsigned GAP_BITS = 2
) (
    input logic                    clock,
    input logic                    reset_b,
    manchester_tx_arbiter_if.slave bus
);

    // Handshake: req_x is a level held until ack_x; ack_x pulses high for
    // exactly one cycle, the cycle right after the edge that captured data_x.
    // Requests are only looked at while IDLE, so changes during busy are ignored.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_e;

    localparam logic [2:0] PRE_LAST  = 3'd3;
    localparam logic [2:0] DATA_LAST = 3'd7;
    localparam logic [2:0] GAP_LAST  = 3'(GAP_BITS - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       phase_q, phase_d;
    logic [7:0] shift_q, shift_d;
    logic       owner_q, owner_d;
    logic       ack_a_q, ack_a_d;
    logic       ack_b_q, ack_b_d;
    logic       nrz_q, nrz_d;
    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;

    logic       grant_a;
    logic       grant_b;
    logic [1:0] pre_idx;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        grant_a = bus.req_a & (~bus.req_b | owner_q);
        grant_b = bus.req_b & (~bus.req_a | ~owner_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        shift_d = shift_q;
        owner_d = owner_q;
        ack_a_d = 1'b0;
        ack_b_d = 1'b0;

        case (state_q)
            IDLE: begin
                phase_d = 1'b0;
                cnt_d   = 3'd0;
                if (grant_a || grant_b) begin
                    state_d = PRE;
                    owner_d = grant_b;
                    ack_a_d = grant_a;
                    ack_b_d = grant_b;
                    shift_d = grant_b ? bus.data_b : bus.data_a;
                end
            end
            PRE: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (cnt_q == PRE_LAST) begin
                        state_d = DATA;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            DATA: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    if (cnt_q == DATA_LAST) begin
                        state_d = GAP;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            GAP: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                        phase_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
                phase_d = 1'b0;
            end
        endcase
    end

    // Outputs are computed from the next state so every output is a flop
    // and the first preamble bit is already on the line in the ack cycle.
    always_comb begin
        pre_idx      = ~cnt_d[1:0];
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == GAP) && (cnt_d == GAP_LAST) && phase_d;
        nrz_d        = 1'b0;
        case (state_d)
            PRE:     nrz_d = PREAMBLE[pre_idx];
            DATA:    nrz_d = shift_d[7];
            default: nrz_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            phase_q      <= 1'b0;
            shift_q      <= 8'd0;
            owner_q      <= 1'b1;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            nrz_q        <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            shift_q      <= shift_d;
            owner_q      <= owner_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            nrz_q        <= nrz_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.ack_a      = ack_a_q;
    assign bus.ack_b      = ack_b_q;
    assign bus.nrz_out    = nrz_q;
    assign bus.bit_phase  = phase_q;
    assign bus.busy       = busy_q;
    assign bus.owner      = owner_q;
    assign bus.frame_done = frame_done_q;
    assign bus.state_dbg  = state_q;

    a_one_ack: assert property (@(posedge clock) disable iff (!reset_b)
        !(ack_a_q && ack_b_q));
    a_busy_state: assert property (@(posedge clock) disable iff (!reset_b)
        busy_q == (state_q != IDLE));

endmodule

// File: tb/tb_manchester_tx_arbiter.sv
// Bench for manchester_tx_arbiter: a directed frame table, hand-written
// corner sequences, then random traffic against a frame-level reference model.
module tb_manchester_tx_arbiter;

    localparam logic [3:0]  PRE_BITS = 4'b1010;
    localparam int unsigned GAP      = 2;

    logic clock;
    logic reset_b;
    int   tests_run;
    int   tests_failed;

    manchester_tx_arbiter_if bus ();

    manchester_tx_arbiter #(
        .PREAMBLE (PRE_BITS),
        .GAP_BITS (GAP)
    ) dut (
        .clock   (clock),
        .reset_b (reset_b),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        bus.req_a  = 1'b0;
        bus.req_b  = 1'b0;
        bus.data_a = 8'h00;
        bus.data_b = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_b = 1'b0;
        tick();
        tick();
        reset_b = 1'b1;
    endtask

    // {ack_a, ack_b, nrz_out, bit_phase, busy, owner, frame_done}
    function automatic logic [6:0] outs();
        return {bus.ack_a, bus.ack_b, bus.nrz_out, bus.bit_phase,
                bus.busy, bus.owner, bus.frame_done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advances until frame_done is seen or the budget runs out.
    task automatic wait_fd(input string name, input int max, output int n, output logic seen_ack_b);
        n = 0;
        seen_ack_b = 1'b0;
        while (!bus.frame_done && n < max) begin
            tick();
            n++;
            seen_ack_b = seen_ack_b | bus.ack_b;
        end
        check({name, "_fd_timeout"}, 32'(bus.frame_done), 32'd1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst_n;
        logic       req_a;
        logic [7:0] data_a;
        logic       req_b;
        logic [7:0] data_b;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[31];

    // ---------------- reference model ----------------
    logic [0:0] exp_q[$];
    logic       m_owner;
    logic       m_cool;
    int         m_flen;

    function automatic void model_reset();
        exp_q.delete();
        m_owner = 1'b1;
        m_cool  = 1'b0;
    endfunction

    // One rising edge worth of behaviour, from the inputs present at the edge.
    function automatic logic [6:0] model_step(input logic rst, input logic ra, input logic [7:0] da,
                                              input logic rb, input logic [7:0] db);
        logic       ack_a, ack_b, nrz, ph, bsy, fd, win;
        logic [7:0] byte_v;
        int         idx;
        ack_a = 1'b0; ack_b = 1'b0; nrz = 1'b0; ph = 1'b0; bsy = 1'b0; fd = 1'b0;
        if (!rst) begin
            model_reset();
            return {7'b0000010};
        end
        if (exp_q.size() == 0 && !m_cool && (ra || rb)) begin
            win     = (ra && rb) ? ~m_owner : rb;
            m_owner = win;
            ack_a   = ~win;
            ack_b   = win;
            byte_v  = win ? db : da;
            for (int i = 3; i >= 0; i--) begin
                exp_q.push_back(PRE_BITS[i]);
                exp_q.push_back(PRE_BITS[i]);
            end
            for (int i = 7; i >= 0; i--) begin
                exp_q.push_back(byte_v[i]);
                exp_q.push_back(byte_v[i]);
            end
            for (int i = 0; i < 2 * GAP; i++) exp_q.push_back(1'b0);
            m_flen = exp_q.size();
        end else if (exp_q.size() == 0) begin
            m_cool = 1'b0;
            return {5'b00000, m_owner, 1'b0};
        end
        nrz = exp_q.pop_front();
        idx = m_flen - exp_q.size() - 1;
        ph  = idx[0];
        bsy = 1'b1;
        fd  = (exp_q.size() == 0);
        if (fd) m_cool = 1'b1;
        return {ack_a, ack_b, nrz, ph, bsy, m_owner, fd};
    endfunction

    // ---------------- stimulus / scoreboard ----------------
    initial begin
        logic [11:0] pat;
        int          n;
        logic        ackb_seen;
        logic [7:0]  got;
        logic        ra, rb, rst;
        logic [7:0]  da, db;
        logic [6:0]  exp;

        tests_run    = 0;
        tests_failed = 0;
        reset_b      = 1'b0;
        idle_inputs();

        // Table: reset, then a single A5 frame from requester A.
        pat = {PRE_BITS, 8'hA5};
        vecs[0] = '{rst_n: 1'b0, req_a: 1'b0, data_a: 8'h00, req_b: 1'b0, data_b: 8'h00, exp: 7'b0000010};
        for (int k = 1; k <= 30; k++) begin
            vecs[k].rst_n  = 1'b1;
            vecs[k].req_a  = (k == 1);
            vecs[k].data_a = (k == 1) ? 8'hA5 : 8'hFF;
            vecs[k].req_b  = 1'b0;
            vecs[k].data_b = 8'h00;
            if (k <= 28)
                vecs[k].exp = {(k == 1), 1'b0, (k <= 24) ? pat[11 - (k - 1) / 2] : 1'b0,
                               1'((k - 1) % 2), 1'b1, 1'b0, (k == 28)};
            else
                vecs[k].exp = 7'b0000000;
        end

        @(negedge clock);
        for (int i = 0; i < 31; i++) begin
            reset_b    = vecs[i].rst_n;
            bus.req_a  = vecs[i].req_a;
            bus.data_a = vecs[i].data_a;
            bus.req_b  = vecs[i].req_b;
            bus.data_b = vecs[i].data_b;
            tick();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Both requesting after reset: A first, then B after one idle cycle.
        do_reset();
        bus.req_a = 1'b1; bus.data_a = 8'h11;
        bus.req_b = 1'b1; bus.data_b = 8'h22;
        tick();
        check("tie_first_ack", {bus.ack_a, bus.ack_b, bus.owner}, 3'b100);
        bus.req_a = 1'b0;
        wait_fd("tie_a", 40, n, ackb_seen);
        tick();
        check("tie_idle_gap", {bus.busy, bus.ack_b}, 2'b00);
        tick();
        check("tie_second_ack", {bus.ack_a, bus.ack_b, bus.owner}, 3'b011);
        bus.req_b = 1'b0;
        wait_fd("tie_b", 40, n, ackb_seen);
        tick();

        // Requester B alone for three back-to-back frames.
        do_reset();
        bus.req_b = 1'b1; bus.data_b = 8'h5A;
        tick();
        check("rrb_ack0", {bus.ack_b, bus.owner}, 2'b11);
        for (int f = 1; f < 3; f++) begin
            wait_fd($sformatf("rrb_f%0d", f), 40, n, ackb_seen);
            check($sformatf("rrb_len%0d", f), 32'(n), 32'd27);
            tick();
            check($sformatf("rrb_idle%0d", f), {bus.busy, bus.ack_b}, 2'b00);
            tick();
            check($sformatf("rrb_ack%0d", f), {bus.ack_b, bus.owner, bus.ack_a}, 3'b110);
        end
        bus.req_b = 1'b0;
        wait_fd("rrb_last", 40, n, ackb_seen);
        tick();

        // Reset pulse at clock 10 of a frame aborts it; held request restarts.
        do_reset();
        bus.req_a = 1'b1; bus.data_a = 8'h96;
        tick();
        for (int c = 2; c <= 10; c++) tick();
        check("abort_pre_nrz", {bus.nrz_out, bus.bit_phase, bus.busy}, 3'b111);
        reset_b = 1'b0;
        #1;
        check("abort_async", {bus.nrz_out, bus.bit_phase, bus.busy, bus.frame_done, bus.owner}, 5'b00001);
        @(negedge clock);
        tick();
        check("abort_no_fd", 32'(bus.frame_done), 32'd0);
        reset_b = 1'b1;
        tick();
        check("abort_regrant", {bus.ack_a, bus.busy, bus.nrz_out, bus.bit_phase}, 4'b1110);
        bus.req_a = 1'b0;
        wait_fd("abort_frame", 40, n, ackb_seen);
        check("abort_len", 32'(n), 32'd27);
        tick();

        // data_a changing while busy does not alter the sent byte.
        do_reset();
        bus.req_a = 1'b1; bus.data_a = 8'h3C;
        tick();
        bus.req_a = 1'b0; bus.data_a = 8'hFF;
        got = 8'h00;
        for (int c = 2; c <= 24; c++) begin
            tick();
            if (c >= 9 && (c % 2) == 1) got = {got[6:0], bus.nrz_out};
        end
        check("hold_data", 32'(got), 32'h3C);
        wait_fd("hold_frame", 10, n, ackb_seen);
        tick();

        // Short req_b pulse while busy is never acknowledged.
        do_reset();
        bus.req_a = 1'b1; bus.data_a = 8'h81;
        tick();
        bus.req_a = 1'b0;
        tick();
        tick();
        bus.req_b = 1'b1; bus.data_b = 8'h77;
        ackb_seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            ackb_seen = ackb_seen | bus.ack_b;
        end
        bus.req_b = 1'b0;
        check("pulse_no_ack_busy", 32'(ackb_seen), 32'd0);
        wait_fd("pulse_frame", 40, n, ackb_seen);
        check("pulse_no_ack_gap", 32'(ackb_seen), 32'd0);
        tick();
        check("pulse_idle", {bus.state_dbg, bus.nrz_out, bus.busy, bus.ack_b}, 5'b00000);
        tick();
        check("pulse_stay_idle", {bus.state_dbg, bus.busy, bus.ack_b}, 4'b0000);

        // Random traffic against the reference model.
        do_reset();
        model_reset();
        ra = 1'b0; rb = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) ra = ~ra;
            if ($urandom_range(0, 7) == 0) rb = ~rb;
            da  = 8'($urandom);
            db  = 8'($urandom);
            rst = ($urandom_range(0, 399) != 0);
            reset_b    = rst;
            bus.req_a  = ra;
            bus.req_b  = rb;
            bus.data_a = da;
            bus.data_b = db;
            tick();
            exp = model_step(rst, ra, da, rb, db);
            check($sformatf("rand%0d", c), 32'(outs()), 32'(exp));
        end
        reset_b = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/manchester_tx_arbiter.md
MANCHESTER_TX_ARBITER -- requirements
Module: manchester_tx_arbiter

Interface
REQ-001 SHALL have parameter PREAMBLE, default 4'b1010, meaning the 4 NRZ preamble bits sent MSB first before each data byte.
REQ-002 SHALL have parameter GAP_BITS, default 2, meaning the number of idle (NRZ 0) bit periods forced after each frame, range 1..7.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_b  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_a  input  1  requester A has a byte to send; level, held until ack_a.
REQ-006 SHALL have port data_a  input  8  requester A byte; valid while req_a=1.
REQ-007 SHALL have port ack_a  output  1  one-cycle pulse: data_a captured.
REQ-008 SHALL have ports req_b, data_b, ack_b, identical in meaning to the A ports.
REQ-009 SHALL have port nrz_out  output  1  NRZ bit stream for the downstream NRZ-to-Manchester encoder's B_in.
REQ-010 SHALL have port bit_phase  output  1  0 = first clock, 1 = second clock of the current bit period.
REQ-011 SHALL have port busy  output  1  high from grant cycle through last gap cycle.
REQ-012 SHALL have port owner  output  1  source of the current/last frame: 0 = A, 1 = B.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse in the last clock of the gap.

Function
REQ-014 SHALL implement states IDLE, PRE, DATA, GAP; every registered output is driven from registers only.
REQ-015 SHALL hold each NRZ bit on nrz_out for exactly 2 clocks (bit_phase 0 then 1); bit_phase is 0 whenever state is IDLE.
REQ-016 SHALL in IDLE, when any req is high, grant one requester at that edge: ack_x=1 for that cycle, data_x latched into the shift register, owner updated, busy=1, state->PRE, bit count 0.
REQ-017 SHALL arbitrate round-robin: with both requests high, grant the requester not equal to the last granted owner; when only one is high, grant it.
REQ-018 SHALL in PRE drive PREAMBLE bits 3..0, 2 clocks each (8 clocks), then move to DATA.
REQ-019 SHALL in DATA drive the latched byte bits 7..0 MSB first, 2 clocks each (16 clocks), then move to GAP.
REQ-020 SHALL in GAP drive nrz_out=0 for 2*GAP_BITS clocks, pulse frame_done on the last, then go to IDLE with busy=0 at the next edge.
REQ-021 SHALL make the first preamble bit appear on nrz_out in the cycle after the ack edge (grant-to-first-bit latency 1 clock); frame length = 24 + 2*GAP_BITS clocks after grant.
REQ-022 SHALL ignore requests and data-input changes while busy=1; no ack is issued outside IDLE.
REQ-023 SHALL, if a request is withdrawn before grant, issue no ack and send nothing for it.
REQ-024 SHALL, when a request stays high through a frame, grant it in the IDLE cycle immediately after GAP (minimum inter-frame idle 1 clock).
REQ-025 SHALL never assert ack_a and ack_b in the same cycle.
REQ-026 SHALL use a 3-bit counter for bit index/gap count and wrap it to 0 on each state change.

Reset
REQ-027 SHALL on reset_b=0 immediately force: state IDLE, nrz_out 0, bit_phase 0, busy 0, ack_a 0, ack_b 0, frame_done 0, owner 1 (so A wins the first tie), shift register 0.
REQ-028 SHALL abort a frame in progress when reset asserts mid-frame; no frame_done is produced and the aborted byte is not resent.
REQ-029 SHALL resume arbitration at the first rising edge with reset_b=1.

Verification
REQ-030 SHALL cover: reset, req_a=1 data_a=8'hA5 -> ack_a at edge 1; nrz_out = 1,0,1,0 then 1,0,1,0,0,1,0,1, each for 2 clocks; 4 gap clocks of 0; frame_done on clock 28.
REQ-031 SHALL cover: req_a and req_b both high after reset -> A granted first (owner=0), B granted on the first IDLE cycle after A's frame_done (owner=1).
REQ-032 SHALL cover: req_b=1 alone for 3 consecutive frames while req_a=0 -> B granted each time, each grant 1 clock after the prior frame_done.
REQ-033 SHALL cover: reset_b pulsed low at clock 10 of a frame -> nrz_out, busy, bit_phase 0 within the same cycle; no frame_done; req held -> fresh full frame after release.
REQ-034 SHALL cover: data_a changed from 8'h3C to 8'hFF while busy -> transmitted data bits remain 8'h3C.
REQ-035 SHALL cover: req_b pulsed for 3 clocks while busy then dropped -> no ack_b, state IDLE after gap with nrz_out 0.
